gc_tx_serializer: RTL and testbench

Byte-to-bit sequencer for the N64/GC response path. It sits directly upstream of the pulse generator and feeds that stage's `trigger` and `digit` inputs. It accepts response bytes over a valid/ready stream and emits one bit command per 4 µs slot, MSB first. It closes every frame with a stop-bit command.

---
 rtl/gc_tx_serializer.sv | 187 ++++++++++++++++++
 tb/tb_gc_tx_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_tx_serializer.sv
// Byte-to-bit sequencer for the N64/GC response path: accepts bytes on a valid/ready
// stream and issues one bit command per 4 us slot (MSB first), closing each frame with a stop command.
module gc_tx_serializer #(
  parameter int CYCLES_PER_US = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       tx_active,
  output logic       trigger,
  output logic [1:0] digit,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int SLOT_CYCLES = 4 * CYCLES_PER_US;
  localparam int SW          = $clog2(SLOT_CYCLES);
  localparam logic [SW-1:0] BIT_SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] STOP_SLOT_LAST = SW'(CYCLES_PER_US - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIT  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          hold_last_q, hold_last_d;
  logic          cur_last_q, cur_last_d;
  logic          ur_flag_q, ur_flag_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;
  logic          armed_q, armed_d;

  logic          xfer;
  logic          slot_wrap;

  // armed_q keeps s_ready low while reset is held and until the first clock after release.
  always_comb begin
    s_ready = 1'b0;
    trigger = 1'b0;
    digit   = 2'b11;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = armed_q && !tx_active;
      end
      ST_BIT: begin
        s_ready = !hold_full_q && !cur_last_q && !hold_last_q;
        trigger = (slot_cnt_q == '0);
        digit   = {1'b0, sh_q[7]};
        busy    = 1'b1;
      end
      ST_STOP: begin
        trigger = (slot_cnt_q == '0);
        busy    = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  assign xfer      = s_valid && s_ready;
  assign slot_wrap = (slot_cnt_q == BIT_SLOT_LAST);
  assign done      = done_q;
  assign underrun  = underrun_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    cur_last_d  = cur_last_q;
    ur_flag_d   = ur_flag_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    armed_d     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          sh_d       = s_data;
          cur_last_d = s_last;
          bit_cnt_d  = 3'd7;
          slot_cnt_d = '0;
          state_d    = ST_BIT;
        end
      end

      ST_BIT: begin
        if (xfer) begin
          hold_d      = s_data;
          hold_full_d = 1'b1;
          hold_last_d = s_last;
        end
        if (!slot_wrap) begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end else begin
          slot_cnt_d = '0;
          sh_d       = {sh_q[6:0], 1'b0};
          bit_cnt_d  = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            // A byte arriving on the wrap edge itself is forwarded straight into sh.
            if (cur_last_q) begin
              state_d = ST_STOP;
            end else if (hold_full_q) begin
              sh_d        = hold_q;
              cur_last_d  = hold_last_q;
              hold_full_d = 1'b0;
              hold_last_d = 1'b0;
              bit_cnt_d   = 3'd7;
            end else if (xfer) begin
              sh_d        = s_data;
              cur_last_d  = s_last;
              hold_full_d = 1'b0;
              hold_last_d = 1'b0;
              bit_cnt_d   = 3'd7;
            end else begin
              ur_flag_d = 1'b1;
              state_d   = ST_STOP;
            end
          end
        end
      end

      ST_STOP: begin
        if (slot_cnt_q == STOP_SLOT_LAST) begin
          slot_cnt_d = '0;
          done_d     = 1'b1;
          underrun_d = ur_flag_q;
          ur_flag_d  = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      slot_cnt_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      cur_last_q  <= 1'b0;
      ur_flag_q   <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      cur_last_q  <= cur_last_d;
      ur_flag_q   <= ur_flag_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      armed_q     <= armed_d;
    end
  end

endmodule

// File: tb/tb_gc_tx_serializer.sv
// Self-checking bench for gc_tx_serializer: directed frame table, hand-written corner
// sequences and random frames, all compared against a cycle-timeline model of a frame.
module tb_gc_tx_serializer;

  localparam int C         = 4;
  localparam int SLOT      = 4 * C;
  localparam int BYTE_CYC  = 32 * C;
  localparam logic [6:0] IDLE_EXP  = 7'b1_0_11_0_0_0;
  localparam logic [6:0] RESET_EXP = 7'b0_0_11_0_0_0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       tx_active;
  logic       trigger;
  logic [1:0] digit;
  logic       busy;
  logic       done;
  logic       underrun;

  int errors = 0;
  int checks = 0;
  int fail_prints = 0;

  gc_tx_serializer #(.CYCLES_PER_US(C)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .tx_active(tx_active), .trigger(trigger), .digit(digit),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // A frame plan: the bytes, the relative cycle in which each one is offered (for one cycle),
  // and whether the final byte carries s_last.
  typedef struct {
    logic [3:0][7:0]  bytes;
    logic [3:0][15:0] acc;
    int               nbytes;
    bit               last;
  } plan_t;

  typedef struct {
    plan_t p;
    int    exp_stop;
    int    exp_done;
    bit    exp_ur;
  } vec_t;

  function automatic plan_t mk_plan(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input int n, input int a1,
                                    input int a2, input bit last);
    plan_t p;
    p.bytes  = '0;
    p.acc    = '0;
    p.bytes[0] = b0;
    p.bytes[1] = b1;
    p.bytes[2] = b2;
    p.acc[1] = 16'(a1);
    p.acc[2] = 16'(a2);
    p.nbytes = n;
    p.last   = last;
    return p;
  endfunction

  // Expected {s_ready, trigger, digit, busy, done, underrun} in relative cycle c of a frame
  // whose first byte transfers at the end of cycle 0.
  function automatic logic [6:0] model_out(input plan_t p, input int c);
    int   bits_end;
    int   k;
    int   off;
    int   j;
    int   s;
    logic bitv;
    logic rdy;
    bits_end = BYTE_CYC * p.nbytes;
    if (c == 0) return IDLE_EXP;
    if (c <= bits_end) begin
      k    = (c - 1) / BYTE_CYC;
      off  = (c - 1) % BYTE_CYC;
      j    = off / SLOT;
      s    = off % SLOT;
      bitv = p.bytes[k][7 - j];
      if (k == p.nbytes - 1) rdy = !p.last;
      else                   rdy = (c <= int'(p.acc[k + 1]));
      return {rdy, (s == 0), 1'b0, bitv, 1'b1, 1'b0, 1'b0};
    end
    if (c <= bits_end + C) return {1'b0, (c == bits_end + 1), 2'b11, 1'b1, 1'b0, 1'b0};
    return {1'b1, 1'b0, 2'b11, 1'b0, 1'b1, !p.last};
  endfunction

  task automatic checkOutput(input string name, input int c, input logic [6:0] exp);
    logic [6:0] got;
    got = {s_ready, trigger, digit, busy, done, underrun};
    checks++;
    if (got !== exp) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("[TB] FAIL %s cycle %0d: rdy/trg/dig/busy/done/ur got %b required %b",
                 name, c, got, exp);
      end
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Drives one frame cycle by cycle, checking the whole trace up to and including the done cycle.
  task automatic applyStimulus(input string name, input plan_t p,
                               output int stop_c, output int done_c, output int ur_seen);
    int total;
    total   = BYTE_CYC * p.nbytes + C + 1;
    stop_c  = -1;
    done_c  = -1;
    ur_seen = -1;
    for (int c = 0; c <= total; c++) begin
      tx_active = 1'b0;
      s_valid   = 1'b0;
      s_last    = 1'b0;
      s_data    = 8'($urandom);
      for (int k = 0; k < p.nbytes; k++) begin
        if (c == int'(p.acc[k])) begin
          s_valid = 1'b1;
          s_data  = p.bytes[k];
          s_last  = p.last && (k == p.nbytes - 1);
        end
      end
      @(negedge clk);
      checkOutput(name, c, model_out(p, c));
      if (trigger && digit == 2'b11 && stop_c < 0) stop_c = c;
      if (done && done_c < 0) begin
        done_c  = c;
        ur_seen = int'(underrun);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Idle cycles with tx_active and s_valid wiggled; nothing may start while tx_active is high.
  task automatic idle_cycles(input int n, input bit wiggle);
    for (int i = 0; i < n; i++) begin
      tx_active = wiggle ? 1'($urandom_range(0, 1)) : 1'b0;
      s_valid   = tx_active ? 1'($urandom_range(0, 1)) : 1'b0;
      s_last    = 1'b1;
      s_data    = 8'($urandom);
      @(negedge clk);
      checkOutput("idle", i, {!tx_active, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    tx_active = 1'b0;
    s_valid   = 1'b0;
  endtask

  vec_t  vecs [7];
  plan_t rp;
  int    stop_c;
  int    done_c;
  int    ur_seen;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{p: mk_plan(8'h80, 8'h00, 8'h00, 1, 0, 0, 1'b1),   exp_stop: 129, exp_done: 133, exp_ur: 1'b0};
    vecs[1] = '{p: mk_plan(8'h01, 8'hFE, 8'h00, 2, 1, 0, 1'b1),   exp_stop: 257, exp_done: 261, exp_ur: 1'b0};
    vecs[2] = '{p: mk_plan(8'h55, 8'h00, 8'h00, 1, 0, 0, 1'b0),   exp_stop: 129, exp_done: 133, exp_ur: 1'b1};
    vecs[3] = '{p: mk_plan(8'h12, 8'h34, 8'h00, 2, 128, 0, 1'b1), exp_stop: 257, exp_done: 261, exp_ur: 1'b0};
    vecs[4] = '{p: mk_plan(8'hA5, 8'h3C, 8'hE1, 3, 64, 200, 1'b1), exp_stop: 385, exp_done: 389, exp_ur: 1'b0};
    vecs[5] = '{p: mk_plan(8'hC3, 8'h99, 8'h00, 2, 128, 0, 1'b0), exp_stop: 257, exp_done: 261, exp_ur: 1'b1};
    vecs[6] = '{p: mk_plan(8'hFF, 8'h00, 8'h00, 1, 0, 0, 1'b1),   exp_stop: 129, exp_done: 133, exp_ur: 1'b0};

    reset_n   = 1'b0;
    s_data    = 8'h00;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    tx_active = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 0, RESET_EXP);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(2, 1'b0);

    for (int v = 0; v < 7; v++) begin
      applyStimulus($sformatf("vec%0d", v), vecs[v].p, stop_c, done_c, ur_seen);
      checkValue($sformatf("vec%0d_stop_cycle", v), stop_c, vecs[v].exp_stop);
      checkValue($sformatf("vec%0d_done_cycle", v), done_c, vecs[v].exp_done);
      checkValue($sformatf("vec%0d_underrun", v), ur_seen, int'(vecs[v].exp_ur));
      idle_cycles(3, 1'b0);
    end

    // tx_active held high with a byte waiting: nothing may start.
    tx_active = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'hC3;
    s_last    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("tx_active_gate", i, RESET_EXP);
      @(posedge clk);
      #1;
    end
    applyStimulus("tx_active_release", mk_plan(8'hC3, 8'h00, 8'h00, 1, 0, 0, 1'b1),
                  stop_c, done_c, ur_seen);
    checkValue("tx_release_done_cycle", done_c, 133);
    idle_cycles(2, 1'b0);

    // Reset in the middle of bit 3 of a frame.
    rp = mk_plan(8'hB7, 8'h00, 8'h00, 1, 0, 0, 1'b1);
    s_valid = 1'b1;
    s_data  = 8'hB7;
    s_last  = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3 * SLOT + 5) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("pre_reset_bit3", 1 + 3 * SLOT + 5, model_out(rp, 1 + 3 * SLOT + 5));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_async", 0, RESET_EXP);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("after_reset", i, IDLE_EXP);
      @(posedge clk);
      #1;
    end

    for (int f = 0; f < 10; f++) begin
      rp.bytes  = '0;
      rp.acc    = '0;
      rp.nbytes = $urandom_range(1, 3);
      rp.last   = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < rp.nbytes; k++) begin
        rp.bytes[k] = 8'($urandom);
        if (k > 0) rp.acc[k] = 16'(BYTE_CYC * (k - 1) + $urandom_range(1, BYTE_CYC));
      end
      applyStimulus($sformatf("rand%0d", f), rp, stop_c, done_c, ur_seen);
      checkValue($sformatf("rand%0d_done_cycle", f), done_c, BYTE_CYC * rp.nbytes + C + 1);
      idle_cycles($urandom_range(1, 6), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
